ntt_stream_loader: RTL
======================

# ntt_stream_loader

Sequencer that drives the serial load/start side of an NTT or INTT core (`load_w`, `load_data`, `start`, `din`) from a synchronous-read coefficient buffer, then waits for the core's `done`. It is the transmitter for the core's serial receive protocol: one load pulse, then one word per cycle with no gaps. It sits between the host-filled twiddle/coefficient RAM and one NTTN or INTT instance, and replaces bench-style hand sequencing in the integrated design.

## Interface
- `DATA_SIZE_ARB`, 64: word width of `din` and `rd_data`.
- `RING_DEPTH`, 10: log2 of ring size; `RING_SIZE = 1<<RING_DEPTH`.
- `PE_DEPTH`, 3: log2 of PE count.
- `W_COUNT`, `(((1<<(RING_DEPTH-PE_DEPTH))-1)+PE_DEPTH)<<PE_DEPTH`: twiddle words per load.
- `GAP`, 5: idle cycles inserted after each burst, `din=0`.
- `ADDR_W`, 16: buffer address width.
- `W_BASE`, 0 / `P_BASE`, W_COUNT / `D_BASE`, W_COUNT+2: buffer base addresses for twiddles, the two params (q, n_inv), and coefficients.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `go` in 1: start a job; sampled only in IDLE.
- `with_w` in 1: sampled with `go`. 1 = reload twiddles and params before data.
- `busy` out 1: high from the cycle after `go` is accepted until `job_done`.
- `job_done` out 1: one-cycle pulse when the core's `done` is seen.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out ADDR_W: buffer address. Data returns on `rd_data` one cycle later.
- `rd_data` in DATA_SIZE_ARB: buffer read data.
- `load_w` out 1: one-cycle pulse to the core.
- `load_data` out 1: one-cycle pulse to the core.
- `start` out 1: one-cycle pulse to the core.
- `din` out DATA_SIZE_ARB: serial word to the core.
- `core_done` in 1: the core's `done`.

## Operation
- FSM states: IDLE, W_PULSE, W_STREAM, W_GAP, D_PULSE, D_STREAM, D_GAP, START, WAIT.
- **IDLE.** On `go`: go to W_PULSE if `with_w`, else D_PULSE.
- **W_PULSE (1 cycle).** `load_w=1`, `rd_en=1`, `rd_addr=W_BASE`.
- **W_STREAM (W_COUNT+2 cycles).**
  - `din = rd_data` for word index k, where k = 0..W_COUNT-1 are twiddles and k = W_COUNT, W_COUNT+1 are params read from P_BASE and P_BASE+1.
  - The read for word k+1 is issued in the same cycle word k is driven.
  - No read is issued in the last cycle.
- **W_GAP (GAP cycles).** `din=0`, then go to D_PULSE.
- **D_PULSE (1 cycle).** `load_data=1`, read `D_BASE`.
- **D_STREAM (RING_SIZE cycles).** Words from `D_BASE+k`, same read-ahead scheme as W_STREAM.
- **D_GAP (GAP cycles).** `din=0`, then go to START.
- **START (1 cycle).** `start=1`.
- **WAIT.** Hold until `core_done=1`. Then pulse `job_done` and return to IDLE.
- `din` equals `rd_data` only in cycles where a stream word is due (registered flag). Otherwise `din=0`.
- A single word counter (width `$clog2(max(W_COUNT+2,RING_SIZE))+1`) is cleared on entry to each stream or gap state.
- `rd_addr` is generated as base plus counter. Address wrap is not supported; base+count must fit in ADDR_W (elaboration check).
- Streams are never stalled. The buffer is required to be fully written before `go`.

## Timing
- **Reset.** All outputs are 0 and the FSM is in IDLE. Reset mid-job aborts immediately; no pulse is completed.
- `go` is accepted in cycle 0 (edge). With `with_w=1`:
  - `load_w` at cycle 1, words at cycles 2..W_COUNT+3.
  - Gap, then `load_data` at W_COUNT+GAP+4.
  - Data words at the next RING_SIZE cycles, then GAP idle cycles, then `start`.
- With `with_w=0`: `load_data` at cycle 1, data at cycles 2..RING_SIZE+1, `start` at RING_SIZE+GAP+2.
- `job_done` is asserted the cycle after `core_done` is sampled high in WAIT.
- **Ignored events.**
  - `go` while busy, including the cycle `job_done` pulses.
  - `core_done` outside WAIT.
- `core_done` in the same cycle as the `start` pulse is ignored. WAIT begins the following cycle.

## Structure
- Shared package `ntt_pkg`: state enum, `W_COUNT`/`RING_SIZE` derivation functions, counter-width function.
- One sub-module, `ntt_rd_addr_gen`: base mux, counter, and read-ahead `rd_en`/`rd_addr` generation.
- FSM and `din` mux live in the top module.

## Test plan
Bench parameters: RING_DEPTH=4, PE_DEPTH=1 (W_COUNT=16, RING_SIZE=16), GAP=5; buffer model with 1-cycle latency, `mem[i]=i+100`.
- **With twiddles.** `go`, `with_w=1` at cycle 0 ->
  - `load_w` at cycle 1; `din`=100..117 at cycles 2..19; `din`=0 at cycles 20..24.
  - `load_data` at 25; `din`=118..133 at cycles 26..41; `start` at 47.
- **Data only.** `go`, `with_w=0` -> `load_data` at 1, `din`=118..133 at 2..17, `start` at 23, no `load_w`.
- **Completion.** `core_done` pulse 30 cycles after `start` -> `job_done` one cycle later, `busy` drops with it; `go` again is accepted the next cycle.
- **Spurious inputs.** `go` pulses during D_STREAM and `core_done` during W_STREAM -> no change to the sequence or any counts.
- **Reset mid-job.** `reset` low during D_STREAM word 7 -> all outputs 0 asynchronously; after release, `go` gives a full sequence from cycle 1.
- **Back-to-back.** Two jobs (`with_w=1` then `with_w=0`) -> exact per-cycle compare of `din`, `load_w`, `load_data`, `start` against a golden trace.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared types and elaboration-time helpers for the NTT stream loader.
package ntt_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWPulse,
    StWStream,
    StWGap,
    StDPulse,
    StDStream,
    StDGap,
    StStart,
    StWait
  } state_e;

  function automatic int unsigned ring_size(input int unsigned ring_depth);
    return 32'd1 << ring_depth;
  endfunction

  // Twiddle words per load: one block per stage plus the per-PE extras.
  function automatic int unsigned w_count(input int unsigned ring_depth,
                                          input int unsigned pe_depth);
    return (((32'd1 << (ring_depth - pe_depth)) - 32'd1) + pe_depth) << pe_depth;
  endfunction

  // Wide enough to index the longest stream with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned wc, input int unsigned rs);
    int unsigned longest;
    longest = ((wc + 32'd2) > rs) ? (wc + 32'd2) : rs;
    return 32'($clog2(longest)) + 32'd1;
  endfunction

endpackage

// File: rtl/ntt_rd_addr_gen.sv
// Word counter plus read-ahead address generation for the coefficient buffer.
module ntt_rd_addr_gen
  import ntt_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned W_COUNT   = 16,
  parameter int unsigned RING_SIZE = 16,
  parameter int unsigned W_BASE    = 0,
  parameter int unsigned P_BASE    = 16,
  parameter int unsigned D_BASE    = 18,
  parameter int unsigned CNT_W     = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  state_e            state_i,
  input  state_e            state_d_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o
);

  localparam logic [CNT_W-1:0]  WLast    = CNT_W'(W_COUNT + 1);
  localparam logic [CNT_W-1:0]  WCnt     = CNT_W'(W_COUNT);
  localparam logic [CNT_W-1:0]  DLast    = CNT_W'(RING_SIZE - 1);
  localparam logic [ADDR_W-1:0] WBase    = ADDR_W'(W_BASE);
  // Params follow the twiddles in word index, so rebase them by W_COUNT.
  localparam logic [ADDR_W-1:0] PBaseAdj = ADDR_W'(P_BASE - W_COUNT);
  localparam logic [ADDR_W-1:0] DBase    = ADDR_W'(D_BASE);

  logic [CNT_W-1:0]  cnt_q, cnt_d, nxt;
  logic [CNT_W-1:0]  idx;
  logic [ADDR_W-1:0] base;
  logic              rd_en;

  assign nxt   = cnt_q + CNT_W'(1);
  assign cnt_o = cnt_q;

  // Counter restarts on every state change and advances inside streams and gaps.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d_i != state_i) begin
      cnt_d = '0;
    end else if (state_i inside {StWStream, StWGap, StDStream, StDGap}) begin
      cnt_d = nxt;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read word k+1 while word k is on din; the last stream cycle reads nothing.
  always_comb begin
    rd_en = 1'b0;
    base  = '0;
    idx   = '0;
    case (state_i)
      StWPulse: begin
        rd_en = 1'b1;
        base  = WBase;
      end
      StWStream: begin
        rd_en = (cnt_q != WLast);
        base  = (nxt < WCnt) ? WBase : PBaseAdj;
        idx   = nxt;
      end
      StDPulse: begin
        rd_en = 1'b1;
        base  = DBase;
      end
      StDStream: begin
        rd_en = (cnt_q != DLast);
        base  = DBase;
        idx   = nxt;
      end
      default: ;
    endcase
    rd_en_o   = rd_en;
    rd_addr_o = rd_en ? (base + ADDR_W'(idx)) : '0;
  end

endmodule

// File: rtl/ntt_stream_loader.sv
// Sequences load pulses, gap-free word streams and start for one NTT/INTT core.
module ntt_stream_loader
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_SIZE_ARB = 64,
  parameter int unsigned RING_DEPTH    = 10,
  parameter int unsigned PE_DEPTH      = 3,
  parameter int unsigned W_COUNT       = w_count(RING_DEPTH, PE_DEPTH),
  parameter int unsigned GAP           = 5,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned W_BASE        = 0,
  parameter int unsigned P_BASE        = W_COUNT,
  parameter int unsigned D_BASE        = W_COUNT + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic                     with_w,
  output logic                     busy,
  output logic                     job_done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_SIZE_ARB-1:0] rd_data,
  output logic                     load_w,
  output logic                     load_data,
  output logic                     start,
  output logic [DATA_SIZE_ARB-1:0] din,
  input  logic                     core_done
);

  localparam int unsigned RingSize = ring_size(RING_DEPTH);
  localparam int unsigned CntW     = cnt_width(W_COUNT, RingSize);
  localparam longint unsigned AddrSpace = 64'd1 << ADDR_W;

  localparam logic [CntW-1:0] WLast   = CntW'(W_COUNT + 1);
  localparam logic [CntW-1:0] DLast   = CntW'(RingSize - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP - 1);

  // Address wrap is unsupported, so every region must fit the buffer.
  if (RING_DEPTH <= PE_DEPTH) begin : g_bad_depth
    $error("RING_DEPTH must exceed PE_DEPTH");
  end
  if (GAP < 1 || GAP > (32'd1 << CntW)) begin : g_bad_gap
    $error("GAP must be between 1 and the counter range");
  end
  if (64'(W_BASE) + 64'(W_COUNT) > AddrSpace || 64'(P_BASE) + 64'd2 > AddrSpace ||
      64'(D_BASE) + 64'(RingSize) > AddrSpace) begin : g_bad_addr
    $error("buffer regions do not fit in ADDR_W");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt;
  logic            din_vld_q;
  logic            job_done_q;

  ntt_rd_addr_gen #(
    .ADDR_W   (ADDR_W),
    .W_COUNT  (W_COUNT),
    .RING_SIZE(RingSize),
    .W_BASE   (W_BASE),
    .P_BASE   (P_BASE),
    .D_BASE   (D_BASE),
    .CNT_W    (CntW)
  ) u_rd_addr_gen (
    .clk_i    (clk),
    .rst_ni   (reset),
    .state_i  (state_q),
    .state_d_i(state_d),
    .cnt_o    (cnt),
    .rd_en_o  (rd_en),
    .rd_addr_o(rd_addr)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; go is ignored during the job_done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (go && !job_done_q) state_d = with_w ? StWPulse : StDPulse;
      StWPulse:  state_d = StWStream;
      StWStream: if (cnt == WLast) state_d = StWGap;
      StWGap:    if (cnt == GapLast) state_d = StDPulse;
      StDPulse:  state_d = StDStream;
      StDStream: if (cnt == DLast) state_d = StDGap;
      StDGap:    if (cnt == GapLast) state_d = StStart;
      StStart:   state_d = StWait;
      StWait:    if (core_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // A read issued last cycle means a stream word is due now.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_vld_q  <= 1'b0;
      job_done_q <= 1'b0;
    end else begin
      din_vld_q  <= rd_en;
      job_done_q <= (state_q == StWait) && core_done;
    end
  end

  // Core-side pulses and status decoded from the current state.
  always_comb begin
    load_w    = (state_q == StWPulse);
    load_data = (state_q == StDPulse);
    start     = (state_q == StStart);
    busy      = (state_q != StIdle);
    job_done  = job_done_q;
    din       = din_vld_q ? rd_data : '0;
  end

endmodule
